// File: rtl/config_loader.sv
// ---------------------------------------------------------------------------
// config_loader
//   Streams packed configuration words into a tile's two scan chains,
//   MSB first. The CLB chain is filled first, then the connection
//   (SB -> CB_top -> CB_right) chain. Bits are packed contiguously across the
//   chain boundary. Each scan_en is pulsed only on cycles that carry a real
//   bit, so the chains simply hold while the input stream stalls.
//
// Ports
//   clk_i             single clock, rising edge
//   rst_n_i           synchronous active-low reset
//   start_i           1-cycle pulse, begins a load (honoured in IDLE / DONE)
//   cfg_data_i        configuration word, MSB shifted first
//   cfg_valid_i       cfg_data_i valid
//   cfg_ready_o       word accepted this cycle when cfg_valid_i is also high
//   clb_scan_data_o   serial bit to the CLB chain
//   clb_scan_en_o     CLB chain shift enable
//   conn_scan_data_o  serial bit to the connection chain
//   conn_scan_en_o    connection chain shift enable
//   busy_o            high while loading or flushing
//   done_o            high after a complete load, until next start or reset
// ---------------------------------------------------------------------------
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | out of reset, waiting for start
// S_CLB   | shifting buffered bits into the CLB chain
// S_CONN  | shifting buffered bits into the connection chain
// S_FLUSH | one cycle so the chain samples the last registered bit
// S_DONE  | load complete; done_o held until the next start
// ---------------------------------------------------------------------------
module config_loader #(
  parameter int DATA_WIDTH     = 8,
  parameter int CLB_CHAIN_LEN  = 64,
  parameter int CONN_CHAIN_LEN = 96,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] cfg_data_i,
  input  logic                  cfg_valid_i,
  output logic                  cfg_ready_o,
  output logic                  clb_scan_data_o,
  output logic                  clb_scan_en_o,
  output logic                  conn_scan_data_o,
  output logic                  conn_scan_en_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_WIDTH-1:0] CLB_LAST  = CNT_WIDTH'(CLB_CHAIN_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CONN_LAST = CNT_WIDTH'(CONN_CHAIN_LEN - 1);
  localparam logic [BCW-1:0]       BUF_FULL  = BCW'(DATA_WIDTH);
  localparam logic [BCW-1:0]       BUF_ONE   = BCW'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLB   = 3'd1,
    S_CONN  = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic [BCW-1:0]        buf_cnt_q, buf_cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  clb_data_q, clb_data_d;
  logic                  clb_en_q, clb_en_d;
  logic                  conn_data_q, conn_data_d;
  logic                  conn_en_q, conn_en_d;

  logic loading;
  logic shift;
  logic clb_last;
  logic conn_last;
  logic ready;
  logic load;

  always_comb begin
    loading   = (state_q == S_CLB) || (state_q == S_CONN);
    shift     = loading && (buf_cnt_q != '0);
    clb_last  = (state_q == S_CLB)  && (cnt_q == CLB_LAST);
    conn_last = (state_q == S_CONN) && (cnt_q == CONN_LAST);
    // Refill on the cycle the last buffered bit leaves, so word boundaries
    // cost no bubble. Not on the final conn bit: that word would be an extra
    // one and would only be thrown away.
    ready     = loading &&
                ((buf_cnt_q == '0) || ((buf_cnt_q == BUF_ONE) && !conn_last));
    load      = ready && cfg_valid_i;
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_cnt_d   = buf_cnt_q;
    cnt_d       = cnt_q;
    clb_data_d  = clb_data_q;
    conn_data_d = conn_data_q;
    clb_en_d    = 1'b0;
    conn_en_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d   = S_CLB;
          cnt_d     = '0;
          buf_cnt_d = '0;
        end
      end
      S_FLUSH: state_d = S_DONE;
      default: ;
    endcase

    if (shift) begin
      if (state_q == S_CLB) begin
        clb_data_d = buf_q[DATA_WIDTH-1];
        clb_en_d   = 1'b1;
      end else begin
        conn_data_d = buf_q[DATA_WIDTH-1];
        conn_en_d   = 1'b1;
      end
      buf_d     = buf_q << 1;
      buf_cnt_d = buf_cnt_q - BUF_ONE;
      cnt_d     = cnt_q + CNT_WIDTH'(1);

      if (clb_last) begin
        // Remaining buffer bits carry straight on into the conn chain.
        state_d = S_CONN;
        cnt_d   = '0;
      end else if (conn_last) begin
        state_d   = S_FLUSH;
        buf_d     = '0;
        buf_cnt_d = '0;
        cnt_d     = '0;
      end
    end

    // A load only coincides with a shift when the last bit is leaving, so the
    // fresh word simply replaces the drained buffer.
    if (load) begin
      buf_d     = cfg_data_i;
      buf_cnt_d = BUF_FULL;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      buf_cnt_q   <= '0;
      cnt_q       <= '0;
      clb_data_q  <= 1'b0;
      clb_en_q    <= 1'b0;
      conn_data_q <= 1'b0;
      conn_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      buf_cnt_q   <= buf_cnt_d;
      cnt_q       <= cnt_d;
      clb_data_q  <= clb_data_d;
      clb_en_q    <= clb_en_d;
      conn_data_q <= conn_data_d;
      conn_en_q   <= conn_en_d;
    end
  end

  assign cfg_ready_o      = ready;
  assign clb_scan_data_o  = clb_data_q;
  assign clb_scan_en_o    = clb_en_q;
  assign conn_scan_data_o = conn_data_q;
  assign conn_scan_en_o   = conn_en_q;
  assign busy_o           = (state_q == S_CLB) || (state_q == S_CONN) ||
                            (state_q == S_FLUSH);
  assign done_o           = (state_q == S_DONE);

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

  localparam int DW   = 8;
  localparam int CLB  = 12;
  localparam int CONN = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_data = '0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          clb_scan_data, clb_scan_en;
  logic          conn_scan_data, conn_scan_en;
  logic          busy, done;

  config_loader #(
    .DATA_WIDTH    (DW),
    .CLB_CHAIN_LEN (CLB),
    .CONN_CHAIN_LEN(CONN),
    .CNT_WIDTH     (16)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .cfg_data_i      (cfg_data),
    .cfg_valid_i     (cfg_valid),
    .cfg_ready_o     (cfg_ready),
    .clb_scan_data_o (clb_scan_data),
    .clb_scan_en_o   (clb_scan_en),
    .conn_scan_data_o(conn_scan_data),
    .conn_scan_en_o  (conn_scan_en),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [DW-1:0] offer_q[$];
  logic [DW-1:0] acc_q[$];
  logic          clb_q[$];
  logic          conn_q[$];
  int            clb_e[$];
  int            conn_e[$];
  int            busy_first, busy_last, busy_cnt, done_edge;
  logic          done_e0;

  // Reference: the chains see the offered words as one MSB-first bit stream,
  // the first CLB bits to the CLB chain and the next CONN bits to conn.
  function automatic logic mbit(int k);
    logic [DW-1:0] w;
    w = offer_q[k / DW];
    return w[DW-1-(k % DW)];
  endfunction

  function automatic logic [CLB-1:0] exp_clb();
    logic [CLB-1:0] v;
    for (int i = 0; i < CLB; i++) v[CLB-1-i] = mbit(i);
    return v;
  endfunction

  function automatic logic [CONN-1:0] exp_conn();
    logic [CONN-1:0] v;
    for (int i = 0; i < CONN; i++) v[CONN-1-i] = mbit(CLB + i);
    return v;
  endfunction

  function automatic logic [CLB-1:0] got_clb();
    logic [CLB-1:0] v;
    v = '0;
    for (int i = 0; i < clb_q.size() && i < CLB; i++) v[CLB-1-i] = clb_q[i];
    return v;
  endfunction

  function automatic logic [CONN-1:0] got_conn();
    logic [CONN-1:0] v;
    v = '0;
    for (int i = 0; i < conn_q.size() && i < CONN; i++) v[CONN-1-i] = conn_q[i];
    return v;
  endfunction

  function automatic logic [3*DW-1:0] got_acc3();
    logic [3*DW-1:0] v;
    v = '0;
    for (int i = 0; i < acc_q.size() && i < 3; i++) v[(2-i)*DW +: DW] = acc_q[i];
    return v;
  endfunction

  function automatic logic [3*DW-1:0] exp_acc3();
    return {offer_q[0], offer_q[1], offer_q[2]};
  endfunction

  // Runs one load from start to done. Edge numbering: rel=0 is the edge that
  // samples start; outputs are observed at the negedge after edge rel.
  task automatic run_load(input int stall_word, input int stall_len,
                          input int rand_pct, input int busy_start_at);
    int   idx, rel, stall_left;
    logic hs;
    acc_q.delete(); clb_q.delete(); conn_q.delete();
    clb_e.delete(); conn_e.delete();
    busy_first = -1; busy_last = -1; busy_cnt = 0; done_edge = -1; done_e0 = 1'bx;
    @(negedge clk);
    start = 1'b1; cfg_valid = 1'b0;
    @(posedge clk);
    rel = 0; idx = 0; stall_left = stall_len;
    while (done_edge < 0) begin
      @(negedge clk);
      start = (rel == busy_start_at);
      if (clb_scan_en) begin clb_q.push_back(clb_scan_data); clb_e.push_back(rel); end
      if (conn_scan_en) begin conn_q.push_back(conn_scan_data); conn_e.push_back(rel); end
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
        busy_cnt++;
      end
      if (rel == 0) done_e0 = done;
      if (done) begin
        done_edge = rel;
      end else begin
        if (idx == stall_word && stall_left > 0 && cfg_ready) begin
          cfg_valid = 1'b0;
          stall_left--;
        end else if (rand_pct > 0 && int'($urandom_range(99)) < rand_pct) begin
          cfg_valid = 1'b0;
        end else begin
          cfg_valid = 1'b1;
        end
        cfg_data = (idx < offer_q.size()) ? offer_q[idx] : DW'($urandom);
        hs = cfg_valid && cfg_ready;
        @(posedge clk);
        rel++;
        if (hs) begin acc_q.push_back(cfg_data); idx++; end
        if (rel > 400) begin
          cmp_cnt++; err_cnt++;
          $display("FAIL load_timeout: no done after %0d edges, required done", rel);
          done_edge = 9999;
        end
      end
    end
    cfg_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    rst_n = 1'b0; cfg_valid = 1'b1; cfg_data = 8'h5A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = {cfg_ready, clb_scan_data, clb_scan_en, conn_scan_data, conn_scan_en, busy, done};
    cmp_cnt++;
    if (o !== 7'b0) begin
      err_cnt++; $display("FAIL reset_outputs: got %b required 0000000", o);
    end
    rst_n = 1'b1; cfg_valid = 1'b0;
  endtask

  task automatic test_basic();
    offer_q = '{8'hA5, 8'h3C, 8'hF0};
    run_load(-1, 0, 0, -1);
    cmp_cnt++;
    if (got_clb() !== 12'b1010_0101_0011 || clb_q.size() != CLB) begin
      err_cnt++;
      $display("FAIL basic_clb: got %b (%0d bits) required 101001010011 (12 bits)", got_clb(), clb_q.size());
    end
    cmp_cnt++;
    if (got_conn() !== 10'b1100_1111_00 || conn_q.size() != CONN) begin
      err_cnt++;
      $display("FAIL basic_conn: got %b (%0d bits) required 1100111100 (10 bits)", got_conn(), conn_q.size());
    end
    cmp_cnt++;
    if (acc_q.size() != 3 || got_acc3() !== exp_acc3()) begin
      err_cnt++;
      $display("FAIL basic_words: got %0d words %h required 3 words %h", acc_q.size(), got_acc3(), exp_acc3());
    end
  endtask

  task automatic test_timing();
    int cf, cl, nf, nl;
    offer_q = '{8'hA5, 8'h3C, 8'hF0};
    run_load(-1, 0, 0, -1);
    cf = (clb_e.size() > 0) ? clb_e[0] : -1;
    cl = (clb_e.size() > 0) ? clb_e[clb_e.size()-1] : -1;
    nf = (conn_e.size() > 0) ? conn_e[0] : -1;
    nl = (conn_e.size() > 0) ? conn_e[conn_e.size()-1] : -1;
    cmp_cnt++;
    if (cf != 2 || cl != 13 || clb_e.size() != 12) begin
      err_cnt++;
      $display("FAIL timing_clb_en: got first %0d last %0d count %0d required 2 13 12", cf, cl, clb_e.size());
    end
    cmp_cnt++;
    if (nf != 14 || nl != 23 || conn_e.size() != 10) begin
      err_cnt++;
      $display("FAIL timing_conn_en: got first %0d last %0d count %0d required 14 23 10", nf, nl, conn_e.size());
    end
    cmp_cnt++;
    if (done_edge != 24) begin
      err_cnt++; $display("FAIL timing_done: got edge %0d required 24", done_edge);
    end
    cmp_cnt++;
    if (busy_first != 0 || busy_last != 23 || busy_cnt != 24) begin
      err_cnt++;
      $display("FAIL timing_busy: got %0d..%0d (%0d) required 0..23 (24)", busy_first, busy_last, busy_cnt);
    end
    cmp_cnt++;
    if (done_e0 !== 1'b0) begin
      err_cnt++; $display("FAIL restart_done_drop: got done %b after start required 0", done_e0);
    end
  endtask

  task automatic test_stall();
    int e8;
    offer_q = '{8'hA5, 8'h3C, 8'hF0};
    run_load(1, 5, 0, -1);
    e8 = (clb_e.size() > 8) ? clb_e[8] : -1;
    cmp_cnt++;
    if (got_clb() !== exp_clb() || got_conn() !== exp_conn() ||
        clb_q.size() != CLB || conn_q.size() != CONN) begin
      err_cnt++;
      $display("FAIL stall_bits: got %b/%b required %b/%b", got_clb(), got_conn(), exp_clb(), exp_conn());
    end
    cmp_cnt++;
    if (e8 != 15) begin
      err_cnt++; $display("FAIL stall_gap: got 9th clb bit at edge %0d required 15", e8);
    end
    cmp_cnt++;
    if (done_edge != 29) begin
      err_cnt++; $display("FAIL stall_done: got edge %0d required 29", done_edge);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [6:0] o;
    logic       b;
    @(negedge clk);
    start = 1'b1; cfg_valid = 1'b1; cfg_data = DW'($urandom);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (16) begin
      cfg_data = DW'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    b = busy;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o = {cfg_ready, clb_scan_data, clb_scan_en, conn_scan_data, conn_scan_en, busy, done};
    cmp_cnt++;
    if (o !== 7'b0 || b !== 1'b1) begin
      err_cnt++; $display("FAIL midload_reset: got %b (busy before %b) required 0000000 (1)", o, b);
    end
    rst_n = 1'b1; cfg_valid = 1'b0;
    offer_q = '{8'hFF, 8'hFF, 8'hFF};
    run_load(-1, 0, 0, -1);
    cmp_cnt++;
    if (got_clb() !== {CLB{1'b1}} || got_conn() !== {CONN{1'b1}} ||
        clb_q.size() != CLB || conn_q.size() != CONN || acc_q.size() != 3) begin
      err_cnt++;
      $display("FAIL reload_ones: got %b/%b words %0d required all ones, 3 words", got_clb(), got_conn(), acc_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    offer_q = '{8'hA5, 8'h3C, 8'hF0};
    run_load(-1, 0, 0, 5);
    cmp_cnt++;
    if (got_clb() !== 12'b1010_0101_0011 || got_conn() !== 10'b1100_1111_00 ||
        done_edge != 24 || acc_q.size() != 3) begin
      err_cnt++;
      $display("FAIL start_busy: got %b/%b done %0d words %0d required 101001010011/1100111100 24 3",
               got_clb(), got_conn(), done_edge, acc_q.size());
    end
  endtask

  task automatic test_backpressure();
    // DONE: valid held high must not be accepted; done stays sticky.
    @(negedge clk);
    cfg_valid = 1'b1; cfg_data = 8'h77;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      cmp_cnt++;
      if (cfg_ready !== 1'b0 || done !== 1'b1) begin
        err_cnt++; $display("FAIL bp_done: got ready %b done %b required 0 1", cfg_ready, done);
      end
    end
    // IDLE after reset.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      cmp_cnt++;
      if (cfg_ready !== 1'b0 || busy !== 1'b0) begin
        err_cnt++; $display("FAIL bp_idle: got ready %b busy %b required 0 0", cfg_ready, busy);
      end
    end
    cfg_valid = 1'b0;
    offer_q = '{8'h81, 8'h42, 8'h24};
    run_load(-1, 0, 0, -1);
    cmp_cnt++;
    if (acc_q.size() != 3 || got_acc3() !== exp_acc3() || got_clb() !== exp_clb()) begin
      err_cnt++;
      $display("FAIL bp_first_word: got words %h clb %b required %h %b", got_acc3(), got_clb(), exp_acc3(), exp_clb());
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      offer_q = '{DW'($urandom), DW'($urandom), DW'($urandom)};
      run_load(-1, 0, 30, -1);
      cmp_cnt++;
      if (got_clb() !== exp_clb() || got_conn() !== exp_conn() ||
          clb_q.size() != CLB || conn_q.size() != CONN) begin
        err_cnt++;
        $display("FAIL random_bits[%0d]: got %b/%b required %b/%b", n, got_clb(), got_conn(), exp_clb(), exp_conn());
      end
      cmp_cnt++;
      if (acc_q.size() != 3 || got_acc3() !== exp_acc3()) begin
        err_cnt++;
        $display("FAIL random_words[%0d]: got %0d words %h required 3 words %h", n, acc_q.size(), got_acc3(), exp_acc3());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_timing();
    test_stall();
    test_reset_mid_load();
    test_start_while_busy();
    test_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
